// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame decoder: synchronises raw k_clock/k_data, frames 11-bit packets and folds
// E0/F0 prefixes into single make/break key events.
module ps2_key_decoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       k_clock,
  input  logic       k_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   fall, bit_in, timeout;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d, key_break_q, key_break_d;
  logic          key_valid_q, key_valid_d, frame_err_q, frame_err_d;

  // Synchronisers reset high so an idle bus never looks like a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], k_clock};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], k_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in  = dat_sync_q[SYNC_STAGES-1];
  // A fall in the terminal-count cycle wins over the timeout.
  assign timeout = (state_q != StIdle) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;

    if (timeout) begin
      state_d     = StIdle;
      bit_cnt_d   = '0;
      shift_d     = '0;
      tmo_d       = '0;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
      frame_err_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!bit_in) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
        StData: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = bit_in;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (bit_in && (^{shift_q, parity_q})) begin
            if (shift_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_pend_d = 1'b1;
            end else begin
              key_code_d  = shift_q;
              key_ext_d   = ext_pend_q;
              key_break_d = brk_pend_q;
              key_valid_d = 1'b1;
              ext_pend_d  = 1'b0;
              brk_pend_d  = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed frame table, prefix/timeout/reset sequences and random
// frames checked against a byte-level model of the PS/2 key protocol.
module tb_ps2_key_decoder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 200;
  localparam int          HALF = 20;

  logic       clock = 1'b0;
  logic       reset_n, k_clock, k_data;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid, frame_err;

  ps2_key_decoder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .k_clock(k_clock), .k_data(k_data),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_code;
    logic       exp_ext;
    logic       exp_brk;
  } vec_t;

  int chk_cnt = 0, pass_cnt = 0;
  int cyc = 0, vcnt = 0, ecnt = 0, vcyc = 0, stop_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (key_valid) begin
        vcnt = vcnt + 1;
        vcyc = cyc;
      end
      if (frame_err) ecnt = ecnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Data is changed while k_clock is high and sampled by the DUT on the fall.
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      k_data = fr[i];
      repeat (HALF) @(negedge clock);
      if (i == 10) stop_cyc = cyc;
      k_clock = 1'b0;
      repeat (HALF) @(negedge clock);
      k_clock = 1'b1;
    end
    k_data = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bp, input logic bs);
    return {~bs, (~^b) ^ bp, b, 1'b0};
  endfunction

  task automatic run_frame(input string name, input logic [7:0] b, input logic bp,
                           input logic bs, input int ev, input int ee,
                           input logic [7:0] code, input logic ext, input logic brk);
    int v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    send_bits(mk_frame(b, bp, bs), 11);
    chk({name, ".valid_cnt"}, vcnt - v0, ev);
    chk({name, ".err_cnt"}, ecnt - e0, ee);
    chk({name, ".outputs"}, {key_code, key_ext, key_break}, {code, ext, brk});
    if (ev == 1) chk({name, ".latency"}, vcyc - stop_cyc, SYNC + 1);
  endtask

  vec_t vecs[20];
  logic [7:0] m_code;
  logic       m_ext, m_brk, m_oext, m_obrk;

  initial begin
    int v0, e0;
    vecs[0]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
    vecs[1]  = '{8'hF0, 0, 0, 0, 0, 8'h1C, 0, 0};
    vecs[2]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 1};
    vecs[3]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
    vecs[4]  = '{8'hE0, 0, 0, 0, 0, 8'h1C, 0, 0};
    vecs[5]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 0};
    vecs[6]  = '{8'hE0, 0, 0, 0, 0, 8'h75, 1, 0};
    vecs[7]  = '{8'hF0, 0, 0, 0, 0, 8'h75, 1, 0};
    vecs[8]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 1};
    vecs[9]  = '{8'h1C, 1, 0, 0, 1, 8'h75, 1, 1};
    vecs[10] = '{8'h1D, 0, 0, 1, 0, 8'h1D, 0, 0};
    vecs[11] = '{8'hE0, 0, 0, 0, 0, 8'h1D, 0, 0};
    vecs[12] = '{8'h1D, 0, 1, 0, 1, 8'h1D, 0, 0};
    vecs[13] = '{8'h1D, 0, 0, 1, 0, 8'h1D, 0, 0};
    vecs[14] = '{8'hF0, 0, 0, 0, 0, 8'h1D, 0, 0};
    vecs[15] = '{8'hE0, 0, 0, 0, 0, 8'h1D, 0, 0};
    vecs[16] = '{8'h12, 0, 0, 1, 0, 8'h12, 1, 1};
    vecs[17] = '{8'hF0, 0, 0, 0, 0, 8'h12, 1, 1};
    vecs[18] = '{8'hF0, 0, 0, 0, 0, 8'h12, 1, 1};
    vecs[19] = '{8'h12, 0, 0, 1, 0, 8'h12, 0, 1};

    reset_n = 1'b0;
    k_clock = 1'b1;
    k_data  = 1'b1;
    repeat (5) @(negedge clock);
    chk("reset.in", {key_code, key_ext, key_break, key_valid, frame_err}, 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("reset.after", {key_code, key_ext, key_break, key_valid, frame_err}, 32'h0);
    chk("reset.strobes", vcnt + ecnt, 0);

    for (int i = 0; i < 20; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop,
                vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_code, vecs[i].exp_ext, vecs[i].exp_brk);

    // Fall with data high while idle is a bad start bit.
    e0 = ecnt;
    send_bits(11'h7FF, 1);
    chk("bad_start.err", ecnt - e0, 1);

    // Timeout after 4 data bits also drops the pending E0.
    run_frame("t5.e0", 8'hE0, 0, 0, 0, 0, 8'h12, 0, 1);
    v0 = vcnt;
    e0 = ecnt;
    send_bits(mk_frame(8'h23, 0, 0), 5);
    repeat (TMO / 2) @(negedge clock);
    chk("t5.no_early_err", ecnt - e0, 0);
    repeat (TMO) @(negedge clock);
    chk("t5.err_once", ecnt - e0, 1);
    chk("t5.no_valid", vcnt - v0, 0);
    run_frame("t5.next", 8'h23, 0, 0, 1, 0, 8'h23, 0, 0);

    // Reset mid-frame after E0.
    run_frame("t6.e0", 8'hE0, 0, 0, 0, 0, 8'h23, 0, 0);
    v0 = vcnt;
    send_bits(mk_frame(8'h55, 0, 0), 4);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6.in_reset", {key_code, key_ext, key_break, key_valid, frame_err}, 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("t6.no_strobe", vcnt - v0, 0);
    run_frame("t6.next", 8'h74, 0, 0, 1, 0, 8'h74, 0, 0);

    m_code = 8'h74;
    m_oext = 1'b0;
    m_obrk = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       bp, bs;
      int         ev, ee, r;
      r  = $urandom_range(0, 99);
      b  = (r < 25) ? 8'hE0 : (r < 40) ? 8'hF0 : 8'($urandom);
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 19) == 0);
      ev = 0;
      ee = 0;
      if (bp || bs) begin
        ee    = 1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        ev     = 1;
        m_code = b;
        m_oext = m_ext;
        m_obrk = m_brk;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
      end
      run_frame($sformatf("rnd%0d", n), b, bp, bs, ev, ee, m_code, m_oext, m_obrk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
